layer_sequencer: RTL and testbench

LAYER_SEQUENCER -- requirements
Module: layer_sequencer

---
 rtl/nn_pkg.sv | 21 ++
 rtl/layer_sequencer_valid_collector.sv | 49 ++++
 rtl/layer_sequencer.sv | 156 +++++++++++++++
 tb/tb_layer_sequencer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared state encoding and width helper for the neural-network sequencing
// and aggregator blocks.
package nn_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        COLLECT = 2'd2,
        DONE    = 2'd3
    } seq_state_t;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        width = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) width = i + 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/layer_sequencer_valid_collector.sv
// Per-lane result capture for one layer: first strobe on each active lane wins,
// completion is reported in the same cycle the last missing lane arrives.
module valid_collector #(
    parameter int unsigned NUM_NEURON = 6,
    parameter int unsigned VALUE_SIZE = 9
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             clear,
    input  logic                             enable,
    input  logic [NUM_NEURON-1:0]            active,
    input  logic [NUM_NEURON*VALUE_SIZE-1:0] lane_data,
    input  logic [NUM_NEURON-1:0]            lane_valid,
    output logic [NUM_NEURON*VALUE_SIZE-1:0] merged,
    output logic                             any_accept,
    output logic                             complete
);

    logic [NUM_NEURON-1:0]            collected;
    logic [NUM_NEURON-1:0]            accept;
    logic [NUM_NEURON*VALUE_SIZE-1:0] buffer;

    assign accept     = lane_valid & active & ~collected & {NUM_NEURON{enable}};
    assign any_accept = |accept;
    assign complete   = enable && (((collected | accept) & active) == active);

    // Buffer view including this cycle's arrivals, so the sequencer can hand
    // the final values onward on the completion edge.
    always_comb begin
        merged = buffer;
        for (int unsigned i = 0; i < NUM_NEURON; i++) begin
            if (accept[i]) merged[i*VALUE_SIZE +: VALUE_SIZE] = lane_data[i*VALUE_SIZE +: VALUE_SIZE];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            collected <= '0;
            buffer    <= '0;
        end else if (clear) begin
            collected <= '0;
            buffer    <= '0;
        end else if (enable) begin
            collected <= collected | accept;
            buffer    <= merged;
        end
    end

endmodule

// File: rtl/layer_sequencer.sv
// Runs up to LAYER_MAX logical layers on one physical neuron array, chaining
// each layer's collected outputs into the next layer's inputs.
module layer_sequencer import nn_pkg::*; #(
    parameter int unsigned                          NUM_NEURON     = 6,
    parameter int unsigned                          VALUE_SIZE     = 9,
    parameter int unsigned                          LAYER_MAX      = 4,
    parameter logic [NUM_NEURON*LAYER_MAX-1:0]      LAYER_SIZES    = {6'b101010, 6'b111010, 6'b111110, 6'b111111},
    parameter int unsigned                          TIMEOUT_CYCLES = 1024
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [clog2(LAYER_MAX):0]        num_layers,
    input  logic [NUM_NEURON*VALUE_SIZE-1:0] start_input,
    input  logic [NUM_NEURON*VALUE_SIZE-1:0] layer_output,
    input  logic [NUM_NEURON-1:0]            layer_output_valid,
    output logic                             layer_start,
    output logic [clog2(LAYER_MAX)-1:0]      layer_num,
    output logic [NUM_NEURON-1:0]            active,
    output logic [NUM_NEURON*VALUE_SIZE-1:0] layer_input,
    output logic                             busy,
    output logic [NUM_NEURON*VALUE_SIZE-1:0] result,
    output logic                             result_valid,
    input  logic                             result_ready,
    output logic                             timeout_err
);

    localparam int unsigned LW     = clog2(LAYER_MAX);
    localparam int unsigned NLW    = LW + 1;
    localparam int unsigned TW_RAW = clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned TW     = (TW_RAW == 0) ? 1 : TW_RAW;
    localparam int unsigned TLIM   = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

    seq_state_t state, next_state;

    logic [LW-1:0]                    last_layer;
    logic [LW-1:0]                    last_idx;
    logic [LW-1:0]                    next_idx;
    logic [NUM_NEURON-1:0]            mask0;
    logic [NUM_NEURON-1:0]            next_mask;
    logic [TW-1:0]                    tcount;
    logic [NUM_NEURON*VALUE_SIZE-1:0] merged;
    logic                             any_accept;
    logic                             complete;
    logic                             is_last;
    logic                             timeout_hit;

    function automatic logic [NUM_NEURON*VALUE_SIZE-1:0] lane_mask(input logic [NUM_NEURON-1:0] m);
        logic [NUM_NEURON*VALUE_SIZE-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < NUM_NEURON; i++) begin
            v[i*VALUE_SIZE +: VALUE_SIZE] = {VALUE_SIZE{m[i]}};
        end
        return v;
    endfunction

    valid_collector #(
        .NUM_NEURON (NUM_NEURON),
        .VALUE_SIZE (VALUE_SIZE)
    ) u_collector (
        .clk        (clk),
        .rst        (rst),
        .clear      (state == ISSUE),
        .enable     (state == COLLECT),
        .active     (active),
        .lane_data  (layer_output),
        .lane_valid (layer_output_valid),
        .merged     (merged),
        .any_accept (any_accept),
        .complete   (complete)
    );

    // Layer count is stored as the index of the final layer, clamped to 1..LAYER_MAX layers.
    always_comb begin
        if (num_layers == '0)                  last_idx = '0;
        else if (num_layers > NLW'(LAYER_MAX)) last_idx = LW'(LAYER_MAX - 1);
        else                                   last_idx = LW'(num_layers - 1'b1);
    end

    assign mask0       = LAYER_SIZES[NUM_NEURON-1:0];
    assign next_idx    = layer_num + 1'b1;
    assign next_mask   = LAYER_SIZES[32'(next_idx)*NUM_NEURON +: NUM_NEURON];
    assign is_last     = (layer_num == last_layer);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (tcount == TW'(TLIM)) && !any_accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = ISSUE;
            ISSUE:   next_state = COLLECT;
            COLLECT: begin
                if (complete)         next_state = is_last ? DONE : ISSUE;
                else if (timeout_hit) next_state = IDLE;
            end
            DONE:    if (result_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        layer_start = (state == ISSUE);
        busy        = (state != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            layer_num    <= '0;
            active       <= '0;
            layer_input  <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            timeout_err  <= 1'b0;
            last_layer   <= '0;
            tcount       <= '0;
        end else begin
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        layer_num   <= '0;
                        active      <= mask0;
                        layer_input <= start_input & lane_mask(mask0);
                        last_layer  <= last_idx;
                    end
                end
                ISSUE: tcount <= '0;
                COLLECT: begin
                    if (complete) begin
                        if (is_last) begin
                            result       <= merged & lane_mask(active);
                            result_valid <= 1'b1;
                        end else begin
                            layer_num   <= next_idx;
                            active      <= next_mask;
                            layer_input <= merged & lane_mask(next_mask);
                        end
                    end else if (any_accept) begin
                        tcount <= '0;
                    end else if (timeout_hit) begin
                        timeout_err <= 1'b1;
                    end else begin
                        tcount <= tcount + 1'b1;
                    end
                end
                DONE: if (result_ready) result_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_layer_sequencer.sv
// Scoreboard bench for layer_sequencer: directed inferences push expected
// layer launches, results and timeouts; a negedge monitor pops and compares.
module tb_layer_sequencer;

    localparam int K_LS  = 0;
    localparam int K_RES = 1;
    localparam int K_TO  = 2;
    localparam logic [5:0] MASKS [4] = '{6'b111111, 6'b111110, 6'b111010, 6'b101010};

    typedef struct {
        int          kind;
        int          lnum;
        logic [5:0]  mask;
        logic [53:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  num_layers;
    logic [53:0] start_input;
    logic [53:0] layer_output;
    logic [5:0]  layer_output_valid;
    logic        layer_start;
    logic [1:0]  layer_num;
    logic [5:0]  active;
    logic [53:0] layer_input;
    logic        busy;
    logic [53:0] result;
    logic        result_valid;
    logic        result_ready;
    logic        timeout_err;

    int   checks   = 0;
    int   failures = 0;
    int   cnt      = 0;
    exp_t exp_q[$];

    layer_sequencer #(.TIMEOUT_CYCLES(8)) dut (
        .clk                (clk),
        .rst                (rst),
        .start              (start),
        .num_layers         (num_layers),
        .start_input        (start_input),
        .layer_output       (layer_output),
        .layer_output_valid (layer_output_valid),
        .layer_start        (layer_start),
        .layer_num          (layer_num),
        .active             (active),
        .layer_input        (layer_input),
        .busy               (busy),
        .result             (result),
        .result_valid       (result_valid),
        .result_ready       (result_ready),
        .timeout_err        (timeout_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cnt <= cnt + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [8:0] resp(input int k, input int i);
        return 9'((k + 1) * 37 + i * 11 + 3);
    endfunction

    function automatic logic [53:0] lanes(input logic [5:0] m, input int k);
        logic [53:0] v;
        v = '0;
        for (int i = 0; i < 6; i++) if (m[i]) v[i*9 +: 9] = resp(k, i);
        return v;
    endfunction

    function automatic logic [53:0] sin_lanes(input logic [5:0] m);
        logic [53:0] v;
        v = '0;
        for (int i = 0; i < 6; i++) if (m[i]) v[i*9 +: 9] = 9'(9'h1F0 + i);
        return v;
    endfunction

    task automatic push(input int kind, input int lnum, input logic [5:0] m, input logic [53:0] d);
        exp_t e;
        e.kind = kind; e.lnum = lnum; e.mask = m; e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic pop_check(input int kind);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event actual=kind%0d required=none", kind);
            return;
        end
        e = exp_q.pop_front();
        if (e.kind != kind) begin
            failures++;
            $display("FAIL event_kind actual=%0d required=%0d", kind, e.kind);
            return;
        end
        if (kind == K_LS) begin
            chk("ls_layer_num", layer_num, e.lnum);
            chk("ls_active", active, e.mask);
            chk("ls_layer_input", layer_input, e.data);
        end else if (kind == K_RES) begin
            chk("result_data", result, e.data);
        end else begin
            chk("timeout_busy", busy, 0);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (layer_start) pop_check(K_LS);
            if (result_valid && result_ready) pop_check(K_RES);
            if (timeout_err) pop_check(K_TO);
        end
    end

    task automatic wait_ls(output bit ok, output int at);
        ok = 0; at = 0;
        for (int n = 0; n < 40 && !ok; n++) begin
            @(negedge clk);
            if (layer_start) begin ok = 1; at = cnt; end
        end
        if (!ok) begin
            checks++; failures++;
            $display("FAIL ls_wait actual=none required=layer_start");
        end
    endtask

    task automatic respond(input int k, input bit dup, input logic [5:0] vmask, output int c);
        if (dup) begin
            @(posedge clk); #1;
            layer_output = '0; layer_output[5*9 +: 9] = 9'h0AA; layer_output_valid = 6'b100000;
            @(posedge clk); #1;
            layer_output[5*9 +: 9] = 9'h155;
            @(posedge clk); #1;
        end else begin
            repeat (3) @(posedge clk);
            #1;
        end
        layer_output = lanes(6'b111111, k);
        layer_output_valid = vmask;
        c = cnt;
        @(posedge clk); #1;
        layer_output_valid = '0;
    endtask

    task automatic do_start(input logic [2:0] nl);
        @(posedge clk); #1;
        start = 1'b1; num_layers = nl; start_input = sin_lanes(6'b111111);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_inference(input logic [2:0] nl, input int eff, input bit dup, input bit hold);
        logic [53:0] d;
        logic [53:0] res;
        int c, at;
        bit ok;
        c = 0;
        for (int k = 0; k < eff; k++) begin
            d = (k == 0) ? sin_lanes(MASKS[0]) : lanes(MASKS[k], k - 1);
            if (dup && k == 2) d[5*9 +: 9] = 9'h0AA;
            push(K_LS, k, MASKS[k], d);
        end
        res = lanes(MASKS[eff-1], eff - 1);
        push(K_RES, 0, MASKS[eff-1], res);
        do_start(nl);
        for (int k = 0; k < eff; k++) begin
            wait_ls(ok, at);
            if (!ok) return;
            if (k > 0) chk("ls_latency", at + 1, c + 2);
            chk("busy_run", busy, 1);
            respond(k, dup && (k == 1), 6'b111111, c);
        end
        ok = 0;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            if (result_valid) ok = 1;
        end
        chk("result_valid_seen", ok, 1);
        if (hold) begin
            for (int j = 0; j < 5; j++) begin
                @(posedge clk); #1;
                start = j[0];
                @(negedge clk);
                chk("done_result_stable", result, res);
                chk("done_valid_held", result_valid, 1);
                chk("done_no_launch", layer_start, 0);
            end
        end
        @(posedge clk); #1;
        start = 1'b0; result_ready = 1'b1;
        @(posedge clk); #1;
        result_ready = 1'b0;
        @(negedge clk);
        chk("post_busy", busy, 0);
        chk("post_valid", result_valid, 0);
    endtask

    task automatic timeout_test();
        int c, at;
        bit ok;
        push(K_LS, 0, MASKS[0], sin_lanes(MASKS[0]));
        push(K_TO, 0, '0, '0);
        do_start(3'd1);
        wait_ls(ok, at);
        if (!ok) return;
        respond(0, 1'b0, 6'b110111, c);
        ok = 0;
        for (int n = 0; n < 30 && !ok; n++) begin
            @(negedge clk);
            if (timeout_err) begin ok = 1; at = cnt; end
        end
        chk("timeout_seen", ok, 1);
        chk("timeout_latency", at, (c + 1) + 8);
        chk("timeout_no_result", result_valid, 0);
        repeat (4) @(negedge clk);
        chk("timeout_idle", busy, 0);
        chk("timeout_result_stays_low", result_valid, 0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_layer_start"}, layer_start, 0);
        chk({tag, "_layer_num"}, layer_num, 0);
        chk({tag, "_active"}, active, 0);
        chk({tag, "_layer_input"}, layer_input, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_result"}, result, 0);
        chk({tag, "_result_valid"}, result_valid, 0);
        chk({tag, "_timeout_err"}, timeout_err, 0);
    endtask

    task automatic reset_test();
        int c, at;
        bit ok;
        for (int k = 0; k < 3; k++)
            push(K_LS, k, MASKS[k], (k == 0) ? sin_lanes(MASKS[0]) : lanes(MASKS[k], k - 1));
        do_start(3'd4);
        for (int k = 0; k < 2; k++) begin
            wait_ls(ok, at);
            if (!ok) return;
            respond(k, 1'b0, 6'b111111, c);
        end
        wait_ls(ok, at);
        if (!ok) return;
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        chk("midrst_queue_empty", exp_q.size(), 0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; num_layers = '0; start_input = '0;
        layer_output = '0; layer_output_valid = '0; result_ready = 1'b0;
        #12;
        check_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        run_inference(3'd4, 4, 1'b1, 1'b1);
        run_inference(3'd0, 1, 1'b0, 1'b0);
        run_inference(3'd7, 4, 1'b0, 1'b0);
        timeout_test();
        reset_test();
        run_inference(3'd2, 2, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        chk("final_queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
